// File: rtl/data_memory_pkg.sv
// data_memory_pkg: memory geometry and Program 1 operand/result byte layout
package data_memory_pkg;
   localparam int DM_W = 8;
   localparam int DM_A = 8;
   localparam int DM_DEPTH = 256;
   localparam logic [DM_A-1:0] IN_LO = 8'd0;
   localparam logic [DM_A-1:0] IN_HI = 8'd1;
   localparam logic [DM_A-1:0] OUT_LO = 8'd2;
   localparam logic [DM_A-1:0] OUT_HI = 8'd3;
endpackage

// File: rtl/data_memory_if.sv
// data_memory_if: byte memory bus; master drives DataAddr/ReadMem/MemWrite/DataIn, slave returns DataOut
interface data_memory_if #(
   parameter int W = data_memory_pkg::DM_W,
   parameter int A = data_memory_pkg::DM_A
);
   logic [A-1:0] DataAddr;
   logic ReadMem;
   logic MemWrite;
   logic [W-1:0] DataIn;
   logic [W-1:0] DataOut;
   modport master (output DataAddr, ReadMem, MemWrite, DataIn, input DataOut);
   modport slave (input DataAddr, ReadMem, MemWrite, DataIn, output DataOut);
endinterface

// File: rtl/data_memory.sv
// data_memory: single-port byte memory, synchronous write, combinational read
// ports: clk, reset (sync, active-high, blocks writes only), bus (slave side of data_memory_if)
module data_memory
   import data_memory_pkg::*;
#(
   parameter int W = DM_W,
   parameter int A = DM_A
) (
   input logic clk,
   input logic reset,
   data_memory_if.slave bus
);
   // dm is accessed hierarchically by benches; reset leaves it untouched so preloads survive
   logic [W-1:0] dm [2**A];
   always_ff @(posedge clk)
      if (!reset && bus.MemWrite) dm[bus.DataAddr] <= bus.DataIn;
   always_comb bus.DataOut = bus.ReadMem ? dm[bus.DataAddr] : '0;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard bench for data_memory against an array reference model
module tb_data_memory;
   import data_memory_pkg::*;
   logic clk = 0;
   logic reset;
   data_memory_if #(.W(8), .A(8)) bus ();
   data_memory #(.W(8), .A(8)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   typedef struct { logic [7:0] v; string n; } exp_t;
   exp_t q[$];
   exp_t e;
   logic [7:0] mem [256];
   bit known [256];
   int checks = 0;
   int failures = 0;
   task automatic check(input string n, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", n, act, req);
      end
   endtask
   // Each stimulus cycle pushes at most one expectation; the monitor drains it mid-cycle.
   always @(negedge clk)
      while (q.size() > 0) begin
         e = q.pop_front();
         check(e.n, bus.DataOut, e.v);
      end
   task automatic drive(input logic r, input logic [7:0] a, input logic rm, input logic mw,
                        input logic [7:0] d, input string n);
      @(posedge clk);
      #2;
      reset = r;
      bus.DataAddr = a;
      bus.ReadMem = rm;
      bus.MemWrite = mw;
      bus.DataIn = d;
      if (!rm || known[a]) q.push_back('{rm ? mem[a] : 8'h00, n});
      if (mw && !r) begin
         mem[a] = d;
         known[a] = 1;
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      logic [7:0] a;
      logic rm, mw, r;
      reset = 1;
      bus.DataAddr = 0;
      bus.ReadMem = 0;
      bus.MemWrite = 0;
      bus.DataIn = 0;
      foreach (known[i]) known[i] = 0;
      drive(1, 8'h05, 0, 0, 8'h00, "reset_dout");
      dut.dm[IN_LO] = 8'h80;
      dut.dm[IN_HI] = 8'h01;
      mem[IN_LO] = 8'h80;
      mem[IN_HI] = 8'h01;
      known[IN_LO] = 1;
      known[IN_HI] = 1;
      drive(1, IN_LO, 1, 0, 8'h00, "preload_lo_in_reset");
      drive(1, IN_HI, 1, 0, 8'h00, "preload_hi_in_reset");
      drive(0, 8'h05, 0, 1, 8'hA5, "write5_rm0");
      drive(0, 8'h05, 1, 0, 8'h00, "read5");
      drive(0, 8'h05, 0, 0, 8'h00, "read_disabled");
      drive(1, 8'h05, 1, 1, 8'h3C, "reset_write_old");
      drive(0, 8'h05, 1, 0, 8'h00, "reset_write_blocked");
      check("hier_dm5", dut.dm[5], 8'hA5);
      check("hier_preload_lo", dut.dm[IN_LO], 8'h80);
      check("hier_preload_hi", dut.dm[IN_HI], 8'h01);
      drive(0, OUT_LO, 0, 1, 8'h11, "rdw_setup");
      drive(0, OUT_LO, 1, 1, 8'h22, "rdw_before_edge");
      drive(0, OUT_LO, 1, 0, 8'h00, "rdw_after_edge");
      drive(0, 8'h00, 0, 1, 8'h5A, "wr_addr00");
      drive(0, 8'hFF, 0, 1, 8'hC3, "wr_addrFF");
      drive(0, 8'h00, 1, 0, 8'h00, "rd_addr00");
      drive(0, 8'hFF, 1, 0, 8'h00, "rd_addrFF");
      drive(0, OUT_LO, 0, 1, 8'h00, "res_lo_write");
      drive(0, OUT_HI, 0, 1, 8'h4A, "res_hi_write");
      drive(0, OUT_HI, 1, 0, 8'h00, "res_hi_read");
      check("hier_out_hi", dut.dm[OUT_HI], 8'h4A);
      check("hier_out_lo", dut.dm[OUT_LO], 8'h00);
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: a = 8'($urandom_range(0, 7));
            1: a = 8'($urandom_range(8'hF8, 8'hFF));
            default: a = 8'($urandom);
         endcase
         rm = 1'($urandom);
         mw = 1'($urandom);
         r = ($urandom_range(0, 9) == 0);
         if (rm && !known[a]) rm = 0;
         drive(r, a, rm, mw, 8'($urandom), "random");
      end
      drive(0, 8'h00, 0, 0, 8'h00, "final_idle");
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
